// File: rtl/seq_divider_pkg.sv
// Shared types and display constants for the sequential divider and its 7-segment path.
// NUM_x are active-high segment patterns (bit 7 = dot); PONTO is the dot alone.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] NUM_0 = 8'h3f;
  localparam logic [7:0] NUM_1 = 8'h06;
  localparam logic [7:0] NUM_2 = 8'h5b;
  localparam logic [7:0] NUM_3 = 8'h4f;
  localparam logic [7:0] NUM_4 = 8'h66;
  localparam logic [7:0] NUM_5 = 8'h6d;
  localparam logic [7:0] NUM_6 = 8'h7d;
  localparam logic [7:0] NUM_7 = 8'h07;
  localparam logic [7:0] NUM_8 = 8'h7f;
  localparam logic [7:0] NUM_9 = 8'h6f;
  localparam logic [7:0] PONTO = 8'h80;

endpackage

// File: rtl/seg7_signed_digit.sv
// Signed value to 7-segment pattern: magnitude digit, dot lit for negatives; combinational.
// Magnitudes above 9 show a plain 0 pattern.
module seg7_signed_digit
  import seq_divider_pkg::*;
#(
  parameter int NBITS     = 3,
  parameter int NBITS_SEG = 8
) (
  input  logic signed [NBITS-1:0]     value,
  output logic        [NBITS_SEG-1:0] seg
);

  logic             neg;
  logic [NBITS-1:0] mag;
  logic [7:0]       pat;
  logic             in_range;

  assign neg = value[NBITS-1];
  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign mag = neg ? -value : value;

  always_comb begin
    pat      = NUM_0;
    in_range = 1'b1;
    case (32'(mag))
      32'd0:   pat = NUM_0;
      32'd1:   pat = NUM_1;
      32'd2:   pat = NUM_2;
      32'd3:   pat = NUM_3;
      32'd4:   pat = NUM_4;
      32'd5:   pat = NUM_5;
      32'd6:   pat = NUM_6;
      32'd7:   pat = NUM_7;
      32'd8:   pat = NUM_8;
      32'd9:   pat = NUM_9;
      default: begin
        pat      = NUM_0;
        in_range = 1'b0;
      end
    endcase
  end

  assign seg = NBITS_SEG'((neg && in_range) ? (pat | PONTO) : pat);

endmodule

// File: rtl/seq_divider.sv
// Restoring signed divider, truncating toward zero: done pulses N+2 cycles after start, 1 cycle for /0.
// start is only sampled in IDLE (ignored while busy, no queueing); results held until the next done.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NBITS_OPERATORS = 3,
  parameter int NBITS_SEG       = 8
) (
  input  logic                              clk_2,
  input  logic                              reset,
  input  logic                              start,
  input  logic signed [NBITS_OPERATORS-1:0] dividend,
  input  logic signed [NBITS_OPERATORS-1:0] divisor,
  output logic                              busy,
  output logic                              done,
  output logic signed [NBITS_OPERATORS-1:0] quotient,
  output logic signed [NBITS_OPERATORS-1:0] remainder,
  output logic                              div_by_zero,
  output logic                              overflow,
  output logic        [NBITS_SEG-1:0]       seg
);

  localparam int N     = NBITS_OPERATORS;
  localparam int PW    = N + 1;
  localparam int CNT_W = $clog2(N + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     dvs_mag;
  logic [N-1:0]     qd;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [PW-1:0]    prem;
  logic             dvd_sign;
  logic             dvs_sign;

  logic [PW:0]      wide;
  logic             fits;
  logic             sign_diff;
  logic [N-1:0]     q_fix;
  logic [N-1:0]     r_fix;

  assign wide      = {prem, qd[N-1]};
  assign fits      = (wide >= {2'b00, dvs_mag});
  assign sign_diff = dvd_sign ^ dvs_sign;
  assign q_fix     = sign_diff ? -qd : qd;
  assign r_fix     = dvd_sign ? -prem[N-1:0] : prem[N-1:0];

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      dvs_mag     <= '0;
      qd          <= '0;
      prem        <= '0;
      dvd_sign    <= 1'b0;
      dvs_sign    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor != '0) begin
              state    <= DIV;
              qd       <= dividend[N-1] ? -dividend : dividend;
              dvs_mag  <= divisor[N-1] ? -divisor : divisor;
              dvd_sign <= dividend[N-1];
              dvs_sign <= divisor[N-1];
              prem     <= '0;
              cnt      <= '0;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end
          end
        end

        DIV: begin
          prem <= fits ? PW'(wide - {2'b00, dvs_mag}) : PW'(wide);
          qd   <= {qd[N-2:0], fits};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          state       <= DONE;
          done        <= 1'b1;
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= 1'b0;
          // A positive quotient with its top bit set only arises from min / -1.
          overflow    <= ~sign_diff & qd[N-1];
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  seg7_signed_digit #(
    .NBITS     (N),
    .NBITS_SEG (NBITS_SEG)
  ) u_seg (
    .value (quotient),
    .seg   (seg)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed results, flags, display and handshake corners.
module tb_seq_divider;

  logic              clk_2;
  logic              reset;
  logic              start;
  logic signed [2:0] dividend;
  logic signed [2:0] divisor;
  logic              busy;
  logic              done;
  logic signed [2:0] quotient;
  logic signed [2:0] remainder;
  logic              div_by_zero;
  logic              overflow;
  logic [7:0]        seg;

  int total = 0;
  int bad   = 0;

  seq_divider #(
    .NBITS_OPERATORS (3),
    .NBITS_SEG       (8)
  ) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .seg         (seg)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Pulses start for one edge, then returns in the cycle where done is seen (lat = cycle index, -1 on timeout).
  task automatic do_op(input logic signed [2:0] a, input logic signed [2:0] b, output int lat);
    @(negedge clk_2);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk_2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_2);
    reset = 1'b0;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (quotient !== 3'b000)  begin bad++; $display("FAIL reset_quotient got=%b exp=000", quotient); end
    total++; if (remainder !== 3'b000) begin bad++; $display("FAIL reset_remainder got=%b exp=000", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    total++; if (seg !== 8'h3f)        begin bad++; $display("FAIL reset_seg got=%h exp=3f", seg); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(3'sd3, 3'sd2, lat);
    total++; if (lat !== 5)            begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    total++; if (quotient !== 3'b001)  begin bad++; $display("FAIL basic_quotient got=%b exp=001", quotient); end
    total++; if (remainder !== 3'b001) begin bad++; $display("FAIL basic_remainder got=%b exp=001", remainder); end
    total++; if (div_by_zero !== 1'b0 || overflow !== 1'b0)
                                       begin bad++; $display("FAIL basic_flags got=%b%b exp=00", div_by_zero, overflow); end
    total++; if (seg !== 8'h06)        begin bad++; $display("FAIL basic_seg got=%h exp=06", seg); end
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    @(negedge clk_2);
    total++; if (done !== 1'b0 || busy !== 1'b0)
                                       begin bad++; $display("FAIL basic_after got=%b%b exp=00", done, busy); end
  endtask

  task automatic test_negative();
    int lat;
    do_op(-3'sd3, 3'sd2, lat);
    total++; if (lat !== 5)            begin bad++; $display("FAIL neg_latency got=%0d exp=5", lat); end
    total++; if (quotient !== 3'b111)  begin bad++; $display("FAIL neg_quotient got=%b exp=111", quotient); end
    total++; if (remainder !== 3'b111) begin bad++; $display("FAIL neg_remainder got=%b exp=111", remainder); end
    total++; if (seg !== 8'h86)        begin bad++; $display("FAIL neg_seg got=%h exp=86", seg); end
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(3'sd3, 3'sd0, lat);
    total++; if (lat !== 1)            begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL dbz_ovf got=%b exp=0", overflow); end
    total++; if (quotient !== 3'b000)  begin bad++; $display("FAIL dbz_quotient got=%b exp=000", quotient); end
    total++; if (remainder !== 3'b011) begin bad++; $display("FAIL dbz_remainder got=%b exp=011", remainder); end
    total++; if (seg !== 8'h3f)        begin bad++; $display("FAIL dbz_seg got=%h exp=3f", seg); end
  endtask

  task automatic test_overflow();
    int lat;
    do_op(-3'sd4, -3'sd1, lat);
    total++; if (lat !== 5)            begin bad++; $display("FAIL ovf_latency got=%0d exp=5", lat); end
    total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_dbz got=%b exp=0", div_by_zero); end
    total++; if (quotient !== 3'b100)  begin bad++; $display("FAIL ovf_quotient got=%b exp=100", quotient); end
    total++; if (remainder !== 3'b000) begin bad++; $display("FAIL ovf_remainder got=%b exp=000", remainder); end
    total++; if (seg !== 8'he6)        begin bad++; $display("FAIL ovf_seg got=%h exp=e6", seg); end
  endtask

  // Second start in cycle 2 must be dropped; results from the previous op (-4/-1) hold until done.
  task automatic test_ignore_start();
    int ndone;
    int dcyc;
    int held_bad;
    logic [2:0] q_at;
    logic [2:0] r_at;
    ndone = 0; dcyc = -1; held_bad = 0; q_at = 3'bxxx; r_at = 3'bxxx;
    @(negedge clk_2);
    dividend = 3'sd3;
    divisor  = -3'sd4;
    start    = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin dividend = 3'sd1; divisor = 3'sd1; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (done === 1'b1) begin ndone++; dcyc = c; q_at = quotient; r_at = remainder; end
      if (c < 5 && (quotient !== 3'b100 || remainder !== 3'b000)) held_bad++;
      if (c > 5 && (quotient !== 3'b000 || remainder !== 3'b011)) held_bad++;
      if (c < 12) @(negedge clk_2);
    end
    total++; if (ndone !== 1)       begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
    total++; if (dcyc !== 5)        begin bad++; $display("FAIL ign_done_cycle got=%0d exp=5", dcyc); end
    total++; if (q_at !== 3'b000)   begin bad++; $display("FAIL ign_quotient got=%b exp=000", q_at); end
    total++; if (r_at !== 3'b011)   begin bad++; $display("FAIL ign_remainder got=%b exp=011", r_at); end
    total++; if (held_bad !== 0)    begin bad++; $display("FAIL ign_held got=%0d exp=0", held_bad); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(3'sd2, -3'sd1, lat);
    total++; if (lat !== 5)            begin bad++; $display("FAIL b2b1_latency got=%0d exp=5", lat); end
    total++; if (quotient !== 3'b110)  begin bad++; $display("FAIL b2b1_quotient got=%b exp=110", quotient); end
    total++; if (remainder !== 3'b000) begin bad++; $display("FAIL b2b1_remainder got=%b exp=000", remainder); end
    total++; if (seg !== 8'hdb)        begin bad++; $display("FAIL b2b1_seg got=%h exp=db", seg); end
    do_op(-3'sd3, -3'sd2, lat);
    total++; if (lat !== 5)            begin bad++; $display("FAIL b2b2_latency got=%0d exp=5", lat); end
    total++; if (quotient !== 3'b001)  begin bad++; $display("FAIL b2b2_quotient got=%b exp=001", quotient); end
    total++; if (remainder !== 3'b111) begin bad++; $display("FAIL b2b2_remainder got=%b exp=111", remainder); end
    total++; if (seg !== 8'h06)        begin bad++; $display("FAIL b2b2_seg got=%h exp=06", seg); end
  endtask

  task automatic test_reset_midway();
    int ndone;
    ndone = 0;
    @(negedge clk_2);
    dividend = -3'sd4;
    divisor  = 3'sd3;
    start    = 1'b1;
    @(negedge clk_2);
    start = 1'b0;
    @(negedge clk_2);
    reset = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    total++; if (quotient !== 3'b000)  begin bad++; $display("FAIL rst_mid_quotient got=%b exp=000", quotient); end
    total++; if (remainder !== 3'b000) begin bad++; $display("FAIL rst_mid_remainder got=%b exp=000", remainder); end
    total++; if (div_by_zero !== 1'b0 || overflow !== 1'b0)
                                       begin bad++; $display("FAIL rst_mid_flags got=%b%b exp=00", div_by_zero, overflow); end
    total++; if (seg !== 8'h3f)        begin bad++; $display("FAIL rst_mid_seg got=%h exp=3f", seg); end
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk_2);
    end
    total++; if (ndone !== 0)          begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", ndone); end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_negative();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
